// File: rtl/track_timer_pkg.sv
// Shared encodings and time constants for the track timer controller.
package track_timer_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_REPEAT = 2'd1,
    MODE_SEQ    = 2'd2,
    MODE_LOOP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned SEC_PER_MIN = 60;
  localparam logic [7:0]  SEC_MAX     = 8'(SEC_PER_MIN - 1);

  // Seconds fields never hold more than 59 so min:sec compares as one number.
  function automatic logic [7:0] clamp_sec(input logic [7:0] sec);
    return (sec > SEC_MAX) ? SEC_MAX : sec;
  endfunction

endpackage

// File: rtl/time_mmss_cnt.sv
// Binary minutes:seconds elapsed-time counter with synchronous clear,
// increment and saturation at 255:59.
module time_mmss_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] min_o,
  output logic [7:0] sec_o
);
  import track_timer_pkg::*;

  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (clr) begin
      min_d = 8'd0;
      sec_d = 8'd0;
    end else if (inc) begin
      if (sec_q < SEC_MAX) begin
        sec_d = sec_q + 8'd1;
      end else if (min_q != 8'hFF) begin
        min_d = min_q + 8'd1;
        sec_d = 8'd0;
      end
      // 255:59 holds its value
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= 8'd0;
      sec_q <= 8'd0;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  assign min_o = min_q;
  assign sec_o = sec_q;

endmodule

// File: rtl/track_timer_ctrl.sv
// Playlist transport controller: per-track duration table, IDLE/PLAY/PAUSE
// FSM and end-of-track policy driving a min:sec elapsed-time counter.
module track_timer_ctrl #(
  parameter int         NUM_TRACKS = 4,
  parameter int         TRK_W      = $clog2(NUM_TRACKS),
  parameter logic [7:0] DEF_MIN    = 8'd1,
  parameter logic [7:0] DEF_SEC    = 8'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             play,
  input  logic             pause,
  input  logic             stop,
  input  logic             sel_valid,
  input  logic [TRK_W-1:0] sel_track,
  input  logic [1:0]       mode,
  input  logic             cfg_we,
  input  logic [TRK_W-1:0] cfg_idx,
  input  logic [7:0]       cfg_min,
  input  logic [7:0]       cfg_sec,
  output logic [TRK_W-1:0] cur_track,
  output logic [7:0]       cnt_min,
  output logic [7:0]       cnt_sec,
  output logic             track_end,
  output logic             playing,
  output logic             done
);
  import track_timer_pkg::*;

  localparam logic [TRK_W:0]   NUM_TRACKS_L = (TRK_W+1)'(NUM_TRACKS);
  localparam logic [TRK_W-1:0] LAST_TRK     = TRK_W'(NUM_TRACKS - 1);

  state_e           state_q, state_d;
  logic [TRK_W-1:0] cur_track_q, cur_track_d;
  logic             track_end_q, track_end_d;
  logic             playing_q, playing_d;
  logic             done_q, done_d;

  logic [7:0] dur_min_q [NUM_TRACKS];
  logic [7:0] dur_min_d [NUM_TRACKS];
  logic [7:0] dur_sec_q [NUM_TRACKS];
  logic [7:0] dur_sec_d [NUM_TRACKS];

  logic        sel_ok, cmd_play, cmd_pause, tick_cnt, end_evt;
  logic        cnt_clr, cnt_inc;
  logic [7:0]  cnt_min_w, cnt_sec_w;
  logic [15:0] elapsed, duration;

  // Duration table; a write lands on the next edge, so an end event in the
  // same cycle still compares against the old entry.
  always_comb begin
    for (int i = 0; i < NUM_TRACKS; i++) begin
      dur_min_d[i] = dur_min_q[i];
      dur_sec_d[i] = dur_sec_q[i];
      if (cfg_we && (cfg_idx == TRK_W'(i))) begin
        dur_min_d[i] = cfg_min;
        dur_sec_d[i] = clamp_sec(cfg_sec);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        dur_min_q[i] <= DEF_MIN;
        dur_sec_q[i] <= clamp_sec(DEF_SEC);
      end
    end else begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        dur_min_q[i] <= dur_min_d[i];
        dur_sec_q[i] <= dur_sec_d[i];
      end
    end
  end

  always_comb begin
    sel_ok    = sel_valid && ({1'b0, sel_track} < NUM_TRACKS_L);
    cmd_play  = play && !pause;
    cmd_pause = pause && !play;
    tick_cnt  = tick && (state_q == ST_PLAY) && !stop && !sel_ok;
    elapsed   = {cnt_min_w, cnt_sec_w};
    duration  = {dur_min_q[cur_track_q], dur_sec_q[cur_track_q]};
    end_evt   = tick_cnt && (elapsed >= duration);
  end

  // Next-state and output decode: stop, then select, then transport + tick.
  always_comb begin
    state_d     = state_q;
    cur_track_d = cur_track_q;
    done_d      = done_q;
    track_end_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      done_d  = 1'b0;
    end else if (sel_ok) begin
      cur_track_d = sel_track;
      state_d     = ST_PLAY;
      cnt_clr     = 1'b1;
      done_d      = 1'b0;
    end else begin
      if (cmd_play && (state_q != ST_PLAY)) begin
        state_d = ST_PLAY;
        done_d  = 1'b0;
      end else if (cmd_pause && (state_q == ST_PLAY)) begin
        state_d = ST_PAUSE;
      end

      if (end_evt) begin
        cnt_clr     = 1'b1;
        track_end_d = 1'b1;
        case (mode_e'(mode))
          MODE_SINGLE: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
          MODE_REPEAT: ;
          MODE_SEQ: begin
            if (cur_track_q != LAST_TRK) begin
              cur_track_d = cur_track_q + 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
          MODE_LOOP: begin
            cur_track_d = (cur_track_q == LAST_TRK) ? '0 : cur_track_q + 1'b1;
          end
          default: ;
        endcase
      end else if (tick_cnt) begin
        cnt_inc = 1'b1;
      end
    end

    playing_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_track_q <= '0;
      track_end_q <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_track_q <= cur_track_d;
      track_end_q <= track_end_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
    end
  end

  time_mmss_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .min_o (cnt_min_w),
    .sec_o (cnt_sec_w)
  );

  assign cur_track = cur_track_q;
  assign cnt_min   = cnt_min_w;
  assign cnt_sec   = cnt_sec_w;
  assign track_end = track_end_q;
  assign playing   = playing_q;
  assign done      = done_q;

endmodule

// File: tb/tb_track_timer_ctrl.sv
// Directed bench for track_timer_ctrl: a single-cycle command table plus
// hand-written multi-cycle playlist sequences.
module tb_track_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, play, pause, stop, sel_valid, cfg_we;
  logic [1:0] sel_track, mode, cfg_idx;
  logic [7:0] cfg_min, cfg_sec;
  logic [1:0] cur_track;
  logic [7:0] cnt_min, cnt_sec;
  logic       track_end, playing, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  track_timer_ctrl #(
    .NUM_TRACKS (4),
    .TRK_W      (2),
    .DEF_MIN    (8'd1),
    .DEF_SEC    (8'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .play      (play),
    .pause     (pause),
    .stop      (stop),
    .sel_valid (sel_valid),
    .sel_track (sel_track),
    .mode      (mode),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_min   (cfg_min),
    .cfg_sec   (cfg_sec),
    .cur_track (cur_track),
    .cnt_min   (cnt_min),
    .cnt_sec   (cnt_sec),
    .track_end (track_end),
    .playing   (playing),
    .done      (done)
  );

  typedef struct {
    logic       play, pause, stop, sel_v, tick;
    logic [1:0] sel_t;
    logic       e_play;
    logic [7:0] e_min, e_sec;
    logic [1:0] e_trk;
    logic       e_end, e_done;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic pl, pa, st, sv, input logic [1:0] strk,
                              input logic tk, input logic ep,
                              input logic [7:0] emin, esec,
                              input logic [1:0] etrk, input logic ee, ed);
    vec_t v;
    v.play = pl; v.pause = pa; v.stop = st; v.sel_v = sv; v.sel_t = strk; v.tick = tk;
    v.e_play = ep; v.e_min = emin; v.e_sec = esec; v.e_trk = etrk;
    v.e_end = ee; v.e_done = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tick = 0; play = 0; pause = 0; stop = 0; sel_valid = 0; sel_track = 0;
    cfg_we = 0; cfg_idx = 0; cfg_min = 0; cfg_sec = 0;
  endtask

  task automatic chk(input string name, input logic ep, input logic [7:0] emin, esec,
                     input logic [1:0] etrk, input logic ee, ed);
    logic [20:0] got, exp;
    got = {playing, done, track_end, cur_track, cnt_min, cnt_sec};
    exp = {ep, ed, ee, etrk, emin, esec};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got play=%b done=%b end=%b trk=%0d time=%0d:%0d, want play=%b done=%b end=%b trk=%0d time=%0d:%0d",
               name, playing, done, track_end, cur_track, cnt_min, cnt_sec,
               ep, ed, ee, etrk, emin, esec);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [7:0] m, s);
    cfg_we = 1'b1; cfg_idx = idx; cfg_min = m; cfg_sec = s;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  initial begin
    //          pl pa st sv strk tk | play min  sec trk end done
    vecs[0]  = mk(1, 0, 0, 0, 2'd0, 0,  1, 8'd0, 8'd0, 2'd0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 2'd0, 1,  1, 8'd0, 8'd1, 2'd0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 2'd0, 1,  1, 8'd0, 8'd2, 2'd0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 2'd0, 1,  0, 8'd0, 8'd3, 2'd0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 2'd0, 1,  0, 8'd0, 8'd3, 2'd0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 2'd0, 1,  0, 8'd0, 8'd3, 2'd0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 2'd0, 0,  1, 8'd0, 8'd3, 2'd0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 2'd0, 1,  1, 8'd0, 8'd4, 2'd0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 2'd2, 0,  1, 8'd0, 8'd0, 2'd2, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 2'd0, 1,  1, 8'd0, 8'd1, 2'd2, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 2'd0, 1,  0, 8'd0, 8'd0, 2'd2, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 2'd0, 1,  0, 8'd0, 8'd0, 2'd2, 0, 0);
    vecs[12] = mk(0, 1, 0, 0, 2'd0, 0,  0, 8'd0, 8'd0, 2'd2, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 2'd0, 0,  1, 8'd0, 8'd0, 2'd2, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 2'd1, 1,  1, 8'd0, 8'd0, 2'd1, 0, 0);
    vecs[15] = mk(0, 0, 1, 1, 2'd3, 1,  0, 8'd0, 8'd0, 2'd1, 0, 0);

    mode = 2'd1;
    do_reset();
    chk("reset", 0, 8'd0, 8'd0, 2'd0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      play = vecs[i].play; pause = vecs[i].pause; stop = vecs[i].stop;
      sel_valid = vecs[i].sel_v; sel_track = vecs[i].sel_t; tick = vecs[i].tick;
      step();
      chk($sformatf("vec%0d", i), vecs[i].e_play, vecs[i].e_min, vecs[i].e_sec,
          vecs[i].e_trk, vecs[i].e_end, vecs[i].e_done);
    end
    clear_inputs();

    // Zero duration, REPEAT, and a write coinciding with an end event
    cfg(2'd0, 8'd0, 8'd2);
    cfg(2'd1, 8'd0, 8'd0);
    mode = 2'd1;
    sel_valid = 1; sel_track = 2'd1; step(); sel_valid = 0;
    ticks(1);
    chk("zero_dur_end", 1, 8'd0, 8'd0, 2'd1, 1, 0);
    step();
    chk("end_one_cycle", 1, 8'd0, 8'd0, 2'd1, 0, 0);
    sel_valid = 1; sel_track = 2'd0; step(); sel_valid = 0;
    ticks(2);
    chk("pre_cfg_end", 1, 8'd0, 8'd2, 2'd0, 0, 0);
    tick = 1; cfg_we = 1; cfg_idx = 2'd0; cfg_min = 8'd0; cfg_sec = 8'd5;
    step();
    clear_inputs();
    chk("cfg_same_edge_old", 1, 8'd0, 8'd0, 2'd0, 1, 0);
    ticks(5);
    chk("new_dur_count", 1, 8'd0, 8'd5, 2'd0, 0, 0);
    ticks(1);
    chk("new_dur_end", 1, 8'd0, 8'd0, 2'd0, 1, 0);

    // Asynchronous reset mid-play
    ticks(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 8'd0, 8'd0, 2'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick = 1;
    step();
    tick = 0;
    chk("post_reset", 0, 8'd0, 8'd0, 2'd0, 0, 0);

    // Default table restored, SINGLE mode, 1:00 duration
    mode = 2'd0;
    pulse_play();
    ticks(59);
    chk("single_059", 1, 8'd0, 8'd59, 2'd0, 0, 0);
    ticks(1);
    chk("single_100", 1, 8'd1, 8'd0, 2'd0, 0, 0);
    ticks(1);
    chk("single_end", 0, 8'd0, 8'd0, 2'd0, 1, 1);
    step();
    chk("single_after", 0, 8'd0, 8'd0, 2'd0, 0, 1);
    pulse_play();
    chk("play_clears_done", 1, 8'd0, 8'd0, 2'd0, 0, 0);

    // Pause holds elapsed time
    do_reset();
    pulse_play();
    ticks(5);
    pause = 1; step(); pause = 0;
    ticks(10);
    pulse_play();
    ticks(1);
    chk("pause_resume", 1, 8'd0, 8'd6, 2'd0, 0, 0);

    // Shortening the active track, then clamped seconds
    do_reset();
    mode = 2'd0;
    pulse_play();
    ticks(40);
    cfg(2'd0, 8'd0, 8'd30);
    chk("shorten_hold", 1, 8'd0, 8'd40, 2'd0, 0, 0);
    ticks(1);
    chk("shorten_end", 0, 8'd0, 8'd0, 2'd0, 1, 1);
    cfg(2'd0, 8'd0, 8'd75);
    pulse_play();
    ticks(59);
    chk("clamp_059", 1, 8'd0, 8'd59, 2'd0, 0, 0);
    ticks(1);
    chk("clamp_end", 0, 8'd0, 8'd0, 2'd0, 1, 1);

    // SEQ through all four tracks of 0:02
    do_reset();
    for (int k = 0; k < 4; k++) cfg(2'(k), 8'd0, 8'd2);
    mode = 2'd2;
    pulse_play();
    for (int k = 0; k < 4; k++) begin
      ticks(2);
      chk($sformatf("seq_pre%0d", k), 1, 8'd0, 8'd2, 2'(k), 0, 0);
      ticks(1);
      chk($sformatf("seq_end%0d", k), (k < 3), 8'd0, 8'd0,
          (k < 3) ? 2'(k + 1) : 2'd3, 1, (k == 3));
    end

    // LOOP wraps from the last track
    mode = 2'd3;
    pulse_play();
    chk("loop_play", 1, 8'd0, 8'd0, 2'd3, 0, 0);
    ticks(3);
    chk("loop_wrap", 1, 8'd0, 8'd0, 2'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/track_timer_ctrl.md
TRACK_TIMER_CTRL -- requirements
Module: track_timer_ctrl

Interface
REQ-001 Parameter NUM_TRACKS, default 4, number of tracks in the duration table (2..16).
REQ-002 Parameter TRK_W, default $clog2(NUM_TRACKS), track index width.
REQ-003 Parameter DEF_MIN, default 8'd1, and DEF_SEC, default 8'd0, reset duration of every table entry.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-cycle 1 Hz strobe from an upstream divider.
REQ-007 play, pause, stop  in  1 each  one-cycle transport commands.
REQ-008 sel_valid  in  1  and sel_track  in  TRK_W  direct track select.
REQ-009 mode  in  2  end-of-track policy: 0 SINGLE, 1 REPEAT, 2 SEQ, 3 LOOP.
REQ-010 cfg_we  in  1, cfg_idx  in  TRK_W, cfg_min  in  8, cfg_sec  in  8  duration table write port.
REQ-011 cur_track  out  TRK_W  active track index.
REQ-012 cnt_min, cnt_sec  out  8 each  elapsed play time, binary.
REQ-013 track_end  out  1  one-cycle pulse per completed track.
REQ-014 playing  out  1  high in PLAY; done  out  1  level, playlist finished.

Function
REQ-015 FSM states IDLE, PLAY, PAUSE, with registered outputs only.
REQ-016 Command priority: stop > sel_valid > play/pause; play and pause asserted together are both ignored.
REQ-017 stop: state IDLE, counters cleared to 0:00, cur_track retained, done cleared.
REQ-018 sel_valid with sel_track < NUM_TRACKS: cur_track <= sel_track, counters 0:00, state PLAY, done cleared; sel_track >= NUM_TRACKS ignored entirely.
REQ-019 play in IDLE or PAUSE: state PLAY, counters retained, done cleared; play in PLAY has no effect.
REQ-020 pause in PLAY: state PAUSE; pause in other states has no effect.
REQ-021 tick is counted only in PLAY and only when no stop/sel_valid is asserted in that cycle.
REQ-022 Counted tick with {cnt_min,cnt_sec} < duration(cur_track): cnt_sec increments, 59 wraps to 0 with cnt_min+1; 255:59 saturates.
REQ-023 Counted tick with {cnt_min,cnt_sec} >= duration(cur_track): end event -- counters to 0:00 and track_end=1 on the same edge, then mode action.
REQ-024 Mode SINGLE: state IDLE, cur_track unchanged, done=1.
REQ-025 Mode REPEAT: cur_track unchanged, stay PLAY.
REQ-026 Mode SEQ: cur_track < NUM_TRACKS-1 -> cur_track+1, stay PLAY; else cur_track unchanged, IDLE, done=1.
REQ-027 Mode LOOP: cur_track+1, NUM_TRACKS-1 wraps to 0, stay PLAY.
REQ-028 mode is sampled at the end event; changes mid-track take effect at the next end.
REQ-029 cfg_we writes entry cfg_idx next edge; cfg_sec > 59 stored as 59; cfg_idx >= NUM_TRACKS ignored.
REQ-030 Writes to the active entry take effect immediately; duration below elapsed time ends the track on the next counted tick (>= compare).
REQ-031 Duration 0:00 ends the track on the first counted tick.
REQ-032 cfg_we coincident with an end event on the same entry: comparison uses the old value.

Reset
REQ-033 On rst_n low: state IDLE, cur_track 0, counters 0:00, track_end 0, playing 0, done 0, all table entries DEF_MIN:DEF_SEC.
REQ-034 Reset mid-play discards elapsed time; no track_end is emitted on release.

Structure
REQ-035 Package track_timer_pkg holds the mode encoding, FSM state enum and the seconds-per-minute constant (60).
REQ-036 Sub-module time_mmss_cnt implements the min:sec counter with clear, increment and saturation; table and FSM stay in the top.

Verification
REQ-037 Default table, mode SINGLE, play, 60 ticks -> time 1:00; tick 61 -> track_end pulse, IDLE, done=1, time 0:00.
REQ-038 Mode SEQ, NUM_TRACKS=4, all durations 0:02 -> track_end after ticks 3,6,9,12, cur_track 1,2,3,3, done=1 after the fourth.
REQ-039 Mode LOOP, cur_track 3, end event -> cur_track 0, playing stays 1.
REQ-040 Play, 5 ticks, pause, 10 ticks, play, 1 tick -> time 0:06.
REQ-041 At 0:40 on track 0, write track 0 = 0:30 -> next tick yields track_end; cfg_sec=75 reads back as 59 via end timing.
REQ-042 stop and sel_valid with tick in same cycle -> IDLE, time 0:00, track unchanged, no track_end.
